// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the EX/MEM stage.
package pipe_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } exmem_ctrl_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed single-port RAM: synchronous write, asynchronous read, no reset.
module data_mem
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with stall/flush, data memory access and branch resolution.
module exmem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ALUOutputin,
    input  logic [31:0] WriteDatain,
    input  logic [4:0]  RegWriteAddressin,
    input  logic [31:0] BranchAddressin,
    input  logic        Zeroin,
    input  logic        Branchin,
    input  logic        MemReadin,
    input  logic        MemWritein,
    input  logic        MemToRegin,
    input  logic        RegWritein,
    output logic [31:0] DataMemOut,
    output logic [31:0] ALUOutput,
    output logic [4:0]  RegWriteAddress,
    output logic [31:0] BranchAddress,
    output logic        pcSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        fwd_valid,
    output logic [31:0] fwd_data,
    output logic        misalign,
    output logic        err_sticky
);

    exmem_ctrl_t           ctrl_q;
    logic [WORD_W-1:0]     alu_q;
    logic [WORD_W-1:0]     wdata_q;
    logic [WORD_W-1:0]     baddr_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  zero_q;
    logic                  err_q;
    logic                  mem_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            baddr_q <= '0;
            rd_q    <= '0;
            zero_q  <= 1'b0;
        end else if (flush) begin
            ctrl_q  <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            baddr_q <= '0;
            rd_q    <= '0;
            zero_q  <= 1'b0;
        end else if (!stall) begin
            ctrl_q  <= '{branch:     Branchin,
                         mem_read:   MemReadin,
                         mem_write:  MemWritein,
                         mem_to_reg: MemToRegin,
                         reg_write:  RegWritein};
            alu_q   <= ALUOutputin;
            wdata_q <= WriteDatain;
            baddr_q <= BranchAddressin;
            rd_q    <= RegWriteAddressin;
            zero_q  <= Zeroin;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (misalign) begin
            err_q <= 1'b1;
        end
    end

    assign misalign = (ctrl_q.mem_read | ctrl_q.mem_write) & (alu_q[1:0] != 2'b00);

    // Commit on the edge where the store leaves the stage, so each store writes once.
    assign mem_we = ctrl_q.mem_write & ~misalign & ~stall & ~reset;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (alu_q[ADDR_W+1:2]),
        .wdata (wdata_q),
        .rdata (DataMemOut)
    );

    assign ALUOutput       = alu_q;
    assign RegWriteAddress = rd_q;
    assign BranchAddress   = baddr_q;
    assign MemToReg        = ctrl_q.mem_to_reg;
    assign RegWrite        = ctrl_q.reg_write & ~misalign;
    assign pcSrc           = ctrl_q.branch & zero_q & ~misalign;
    assign fwd_valid       = RegWrite & (rd_q != '0);
    assign fwd_data        = alu_q;
    assign err_sticky      = err_q;

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly upstream of the MEM/WB register.
- Contains three parts:
  - the EX/MEM pipeline register, with stall and flush;
  - a word-addressed data memory;
  - branch resolution logic.
- Produces DataMemOut, ALUOutput, RegWriteAddress, BranchAddress, pcSrc, MemToReg and RegWrite for the MEM/WB register.
- Also drives a forwarding tap back to the EX stage.

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory. Must be a power of two.
- ADDR_W, 8, equal to log2(DEPTH). This is the word-index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the EX/MEM register contents.
- flush  in  1  replace the incoming instruction with a bubble.
- ALUOutputin  in  32  ALU result; this is the memory byte address for loads and stores.
- WriteDatain  in  32  store data, already forwarded.
- RegWriteAddressin  in  5  destination register.
- BranchAddressin  in  32  branch target.
- Zeroin  in  1  ALU zero flag.
- Branchin  in  1  instruction is a branch.
- MemReadin  in  1  instruction is a load.
- MemWritein  in  1  instruction is a store.
- MemToRegin  in  1  writeback selects memory data.
- RegWritein  in  1  writeback enable.
- DataMemOut  out  32  memory read data, combinational from the registered address.
- ALUOutput  out  32  registered ALU result.
- RegWriteAddress  out  5  registered destination register.
- BranchAddress  out  32  registered branch target.
- pcSrc  out  1  taken branch, equal to registered Branch & Zero & ~misalign.
- MemToReg  out  1  registered MemToReg.
- RegWrite  out  1  registered RegWrite, gated by misalign.
- fwd_valid  out  1  equal to RegWrite & (RegWriteAddress != 0).
- fwd_data  out  32  equal to ALUOutput. Loads are not forwarded from this stage; the hazard unit stalls them.
- misalign  out  1  registered access (load or store) has ALUOutput[1:0] != 0.
- err_sticky  out  1  set when misalign is observed; cleared only by reset.

Behaviour:
- Priority on each rising clk edge: reset > flush > stall > load.
- Reset:
  - Every registered field and err_sticky go to 0.
  - All outputs therefore read 0, except DataMemOut, which reads mem[0].
  - Memory contents are not reset.
  - Reset asserted mid-operation kills the in-flight instruction. A store held in the register at that edge is not written.
- Flush:
  - Loads a bubble: all control bits (Branch, MemRead, MemWrite, MemToReg, RegWrite) go to 0 and data fields go to 0.
  - Flush overrides a simultaneous stall.
- Stall:
  - The register holds its contents, and outputs are unchanged.
  - While stalled, a store is not committed.
- Load: with none of reset, flush or stall asserted, all *in inputs are captured. Latency from input to output is 1 cycle.
- Memory write:
  - Condition: registered MemWrite & ~misalign & ~stall & ~reset at the rising edge.
  - Effect: writes the registered WriteData to mem[ALUOutput[ADDR_W+1:2]].
  - This gives exactly one commit per store, on the edge at which the store leaves the stage.
- Memory read:
  - Asynchronous: DataMemOut = mem[ALUOutput[ADDR_W+1:2]] at all times.
  - A store followed by a load to the same word in the next instruction returns the new data, because the write happened on the preceding edge.
- Address wrap: upper address bits above ADDR_W+1 are ignored, so the address wraps modulo DEPTH words.
- Misalignment:
  - misalign is combinational from the registered MemRead|MemWrite and ALUOutput[1:0].
  - When misalign is 1:
    - the store is suppressed;
    - RegWrite output is forced to 0;
    - pcSrc is forced to 0.
  - err_sticky is set on the next edge, unless reset is asserted.
- Branch: pcSrc is valid for exactly the cycle the branch occupies the stage. The hazard unit flushes IF/ID/EX on pcSrc.
- Address zero: fwd_valid is never 1 when RegWriteAddress == 0.

Decomposition:
- Shared package pipe_pkg holds:
  - the EX/MEM control bundle typedef (Branch, MemRead, MemWrite, MemToReg, RegWrite);
  - constants for the word width (32) and the register-address width (5).
- Natural sub-module: data_mem, a single-port RAM with synchronous write and asynchronous read, parameterised by DEPTH and ADDR_W.

Test Plan:
- Reset then release: reset=1 for 2 cycles, then 0 → all control outputs are 0, ALUOutput=0, err_sticky=0.
- Store then load:
  - Store ALUOutputin=0x10, WriteDatain=0xDEADBEEF.
  - Next cycle, load address 0x10 with MemToReg=1, RegWrite=1.
  - Expected → DataMemOut=0xDEADBEEF in the load's cycle; RegWrite=1; RegWriteAddress matches.
- Stall over a store:
  - Store 0xA5A5A5A5 to 0x20, with stall held for 3 cycles and then released.
  - Expected → outputs frozen during the stall.
  - Expected → the memory word is written once, after release.
  - Expected → a load from 0x20 returns 0xA5A5A5A5.
- Flush and stall together:
  - Apply flush=1 and stall=1 while a RegWrite instruction to r5 is on the inputs.
  - Expected → next cycle all control outputs are 0 and fwd_valid=0.
- Branch:
  - Branchin=1, Zeroin=1, BranchAddressin=0x40 → pcSrc=1 for one cycle, BranchAddress=0x40.
  - Same with Zeroin=0 → pcSrc=0.
- Misaligned store:
  - Store to 0x22 with data 0x1.
  - Expected → misalign=1 and the word at 0x20 is unchanged.
  - Expected → err_sticky=1 from the following cycle until reset.
  - Expected → a wrapped address 0x400 (with DEPTH=256) accesses word 0.
